// File: rtl/ritc_align_sequencer.sv
// Alignment initiator for the RITC receive datapath: enables/resets it, loads a default
// IDELAY tap per channel, then bitslips each channel until its training match flag asserts.
module ritc_align_sequencer #(
    parameter int NUM_CH        = 6,
    parameter int TAP_DEFAULT   = 16,
    parameter int MAX_SLIPS     = 8,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic              user_clk_i,
    input  logic              user_rst_i,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] ch_match_i,
    output logic              user_sel_o,
    output logic              user_wr_o,
    output logic [3:0]        user_addr_o,
    output logic [31:0]       user_dat_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [NUM_CH-1:0] locked_o,
    output logic              err_o
);

    localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [3:0]      SLIP_LIMIT  = 4'(MAX_SLIPS);
    localparam logic [9:0]      SETTLE_LOAD = 10'(SETTLE_CYCLES - 1);
    localparam logic [4:0]      TAP_VAL     = 5'(TAP_DEFAULT);

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_SLIP  = 4'h1;
    localparam logic [3:0] ADDR_DELAY = 4'h2;
    localparam logic [3:0] ADDR_LOAD  = 4'h3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN,
        S_RST,
        S_TAP,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ch_q;
    logic [3:0]        slip_q;
    logic [9:0]        settle_q;
    logic [NUM_CH-1:0] locked_q;
    logic              err_q;
    logic              match;

    assign match = ch_match_i[ch_q];

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_EN;
            S_EN:     state_d = S_RST;
            S_RST:    state_d = S_TAP;
            S_TAP:    state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (settle_q == 10'd0) state_d = S_CHECK;
            S_CHECK: begin
                if (match || (slip_q == SLIP_LIMIT)) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_SLIP;
                end
            end
            S_SLIP:   state_d = S_SETTLE;
            S_NEXT:   state_d = (ch_q == LAST_CH) ? S_DONE : S_TAP;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Settle counter reloads on every SETTLE entry so SETTLE lasts exactly SETTLE_CYCLES cycles.
    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            ch_q     <= '0;
            slip_q   <= '0;
            settle_q <= '0;
            locked_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ch_q     <= '0;
                        locked_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    slip_q   <= '0;
                    settle_q <= SETTLE_LOAD;
                end
                S_SLIP: begin
                    slip_q   <= slip_q + 4'd1;
                    settle_q <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_q != 10'd0) begin
                        settle_q <= settle_q - 10'd1;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        locked_q[ch_q] <= 1'b1;
                    end else if (slip_q == SLIP_LIMIT) begin
                        err_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (ch_q != LAST_CH) begin
                        ch_q <= ch_q + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus fields are only non-zero in write states; the datapath has no handshake.
    always_comb begin
        user_sel_o  = 1'b0;
        user_wr_o   = 1'b0;
        user_addr_o = 4'h0;
        user_dat_o  = 32'h0;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        case (state_q)
            S_EN: begin
                user_sel_o  = 1'b1;
                user_wr_o   = 1'b1;
                user_addr_o = ADDR_CTRL;
                user_dat_o  = 32'h0;
            end
            S_RST: begin
                user_sel_o  = 1'b1;
                user_wr_o   = 1'b1;
                user_addr_o = ADDR_CTRL;
                user_dat_o  = 32'h2;
            end
            S_TAP: begin
                user_sel_o  = 1'b1;
                user_wr_o   = 1'b1;
                user_addr_o = ADDR_DELAY;
                user_dat_o  = {27'h0, TAP_VAL};
            end
            S_LOAD: begin
                user_sel_o  = 1'b1;
                user_wr_o   = 1'b1;
                user_addr_o = ADDR_LOAD;
                user_dat_o  = 32'h8000_0000 | 32'(ch_q);
            end
            S_SLIP: begin
                user_sel_o  = 1'b1;
                user_wr_o   = 1'b1;
                user_addr_o = ADDR_SLIP;
                user_dat_o  = 32'h1 << ch_q;
            end
            default: ;
        endcase
    end

    assign locked_o = locked_q;
    assign err_o    = err_q;

endmodule
